// File: rtl/mode_counter.sv
// mode_counter: up/down counter with wrap, saturate, modulo-N and Gray modes.
// Ports: clk, rst (async, active-high), en, up, mode[1:0], load,
//   load_val[W], limit[W] -> q[W] (Gray in mode 11), tc (registered flag).
module mode_counter #(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  typedef enum logic [1:0] {
    M_WRAP = 2'b00,
    M_SAT  = 2'b01,
    M_MOD  = 2'b10,
    M_GRAY = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam logic [WIDTH-1:0] MAXV  = '1;
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  mode_e            md;

  assign md = mode_e'(mode);

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      unique case (md)
        M_WRAP, M_GRAY: begin
          if (up) begin
            cnt_d = cnt_q + ONE;
            tc_d  = (cnt_q == MAXV);
          end else begin
            cnt_d = cnt_q - ONE;
            tc_d  = (cnt_q == ZERO);
          end
        end
        M_SAT: begin
          // At the bound the count holds and tc is reasserted every step.
          if (up) begin
            if (cnt_q == MAXV) tc_d = 1'b1;
            else cnt_d = cnt_q + ONE;
          end else begin
            if (cnt_q == ZERO) tc_d = 1'b1;
            else cnt_d = cnt_q - ONE;
          end
        end
        M_MOD: begin
          // Out-of-range counts (above limit) fold back on the next step.
          if (up) begin
            if (cnt_q >= limit) begin
              cnt_d = ZERO;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end else begin
            if (cnt_q == ZERO || cnt_q > limit) begin
              cnt_d = limit;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
          tc_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_V;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign q  = (md == M_GRAY) ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;
  assign tc = tc_q;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: directed and random checks of mode_counter (WIDTH=4)
// against an arithmetic reference model.
module tb_mode_counter;

  localparam int W = 4;
  localparam int M = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] q;
  logic         tc;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  int mcnt = 0;
  bit mtc = 1'b0;

  mode_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .mode(mode),
    .load(load), .load_val(load_val), .limit(limit),
    .q(q), .tc(tc)
  );

  always #5 clk = ~clk;

  function automatic void model_step(
    input int c, input bit ld, input int lv, input bit e,
    input bit u, input int m, input int l,
    output int nc, output bit t
  );
    int d;
    nc = c;
    t  = 1'b0;
    d  = u ? c + 1 : c - 1;
    if (ld) begin
      nc = lv;
    end else if (e) begin
      case (m)
        1: begin
          if (d < 0 || d >= M) t = 1'b1;
          else nc = d;
        end
        2: begin
          if (u) begin
            if (c >= l) begin nc = 0; t = 1'b1; end
            else nc = c + 1;
          end else begin
            if (c == 0 || c > l) begin nc = l; t = 1'b1; end
            else nc = c - 1;
          end
        end
        default: begin
          t  = (d < 0 || d >= M);
          nc = (d + M) % M;
        end
      endcase
    end
  endfunction

  function automatic int exp_q(input int c, input int m);
    return (m == 3) ? (c ^ (c / 2)) : c;
  endfunction

  always @(posedge clk or posedge rst) begin
    int nc;
    bit nt;
    if (rst) begin
      mcnt <= 0;
      mtc  <= 1'b0;
    end else begin
      model_step(mcnt, load, int'(load_val), en, up,
                 int'(mode), int'(limit), nc, nt);
      mcnt <= nc;
      mtc  <= nt;
    end
  end

  always @(negedge clk) begin
    int e;
    if (chk_on) begin
      e = exp_q(mcnt, int'(mode));
      tests++;
      if (q !== W'(e) || tc !== mtc) begin
        fails++;
        $display("FAIL model t=%0t q=%0d tc=%0b expected q=%0d tc=%0b",
                 $time, q, tc, e, mtc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int aq, input int at,
                     input int eq, input int et);
    tests++;
    if (aq != eq || at != et) begin
      fails++;
      $display("FAIL %s q=%0d tc=%0d expected q=%0d tc=%0d",
               nm, aq, at, eq, et);
    end
  endtask

  task automatic do_load(input int v);
    load = 1'b1;
    load_val = W'(v);
    tick();
    load = 1'b0;
  endtask

  initial begin
    int gray_exp[8];
    gray_exp = '{1, 3, 2, 6, 7, 5, 4, 12};

    tick();
    tick();
    chk("reset_hold", int'(q), int'(tc), 0, 0);
    rst = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("reset_release", int'(q), int'(tc), 0, 0);

    // async reset mid-cycle
    mode = 2'b00; up = 1'b1; en = 1'b1;
    repeat (6) tick();
    chk("count_to_6", int'(q), int'(tc), 6, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", int'(q), int'(tc), 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_held", int'(q), int'(tc), 0, 0);
    end
    en = 1'b0;
    rst = 1'b0;
    tick();

    // BIN_WRAP up then down
    en = 1'b1; up = 1'b1; mode = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("wrap_up", int'(q), int'(tc), i % 16, (i == 16) ? 1 : 0);
    end
    up = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("wrap_dn", int'(q), int'(tc), 16 - i, (i == 1) ? 1 : 0);
    end

    // BIN_SAT down
    en = 1'b0; mode = 2'b01;
    do_load(2);
    en = 1'b1; up = 1'b0;
    tick(); chk("sat_dn0", int'(q), int'(tc), 1, 0);
    tick(); chk("sat_dn1", int'(q), int'(tc), 0, 0);
    tick(); chk("sat_dn2", int'(q), int'(tc), 0, 1);
    tick(); chk("sat_dn3", int'(q), int'(tc), 0, 1);
    en = 1'b0;
    tick(); chk("sat_idle", int'(q), int'(tc), 0, 0);

    // MODULO limit 5
    mode = 2'b10; limit = 4'd5; up = 1'b1; en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("mod_up", int'(q), int'(tc), i % 6, (i == 6) ? 1 : 0);
    end
    up = 1'b0;
    tick(); chk("mod_dn_wrap", int'(q), int'(tc), 5, 1);
    en = 1'b0;
    do_load(9);
    chk("mod_load9", int'(q), int'(tc), 9, 0);
    en = 1'b1; up = 1'b1;
    tick(); chk("mod_over", int'(q), int'(tc), 0, 1);
    limit = 4'd0;
    for (int i = 0; i < 3; i++) begin
      up = (i != 1);
      tick();
      chk("mod_lim0", int'(q), int'(tc), 0, 1);
    end

    // GRAY up, then mode switch
    en = 1'b0;
    do_load(0);
    mode = 2'b11; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("gray_up", int'(q), int'(tc), gray_exp[i], 0);
    end
    en = 1'b0;
    do_load(5);
    chk("gray_5", int'(q), int'(tc), 7, 0);
    mode = 2'b00;
    #1;
    chk("mode_sw", int'(q), int'(tc), 5, 0);

    // load beats enable
    load = 1'b1; en = 1'b1; load_val = 4'd9;
    tick();
    chk("load_en", int'(q), int'(tc), 9, 0);
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold9", int'(q), int'(tc), 9, 0);
    end

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) < 8);
      up       = $urandom_range(0, 3) != 0 ? up : ~up;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 4'($urandom);
      if ($urandom_range(0, 31) == 0) limit = 4'($urandom);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
      rst = 1'b0;
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
